// File: rtl/common_fifo_stream_reader_pkg.sv
// Shared constants and helpers for the FIFO stream reader slice.
package common_fifo_stream_reader_pkg;

    localparam int STREAM_PREFETCH_DEPTH = 3;
    localparam int CNT_W = 2;

    typedef logic [CNT_W-1:0] buf_cnt_t;

    // Pointers wrap modulo the prefetch depth rather than a power of two.
    function automatic logic [1:0] ptr_next(input logic [1:0] ptr);
        return (ptr == 2'(STREAM_PREFETCH_DEPTH - 1)) ? 2'd0 : ptr + 2'd1;
    endfunction

endpackage

// File: rtl/common_fifo_stream_reader_if.sv
// FIFO read port and valid/ready stream bundled together; master is the reader side.
interface common_fifo_stream_reader_if #(
    parameter int DSIZE = 8
);
    logic [DSIZE-1:0] fifo_rdata;
    logic             fifo_empty;
    logic             rd_en;
    logic [DSIZE-1:0] tdata;
    logic             tvalid;
    logic             tready;
    logic             tlast;

    modport master (
        input  fifo_rdata, fifo_empty, tready,
        output rd_en, tdata, tvalid, tlast
    );

    modport slave (
        output fifo_rdata, fifo_empty, tready,
        input  rd_en, tdata, tvalid, tlast
    );
endinterface

// File: rtl/common_fifo_stream_reader_skid3.sv
// Three-entry ordered prefetch buffer with wrap-around pointers; head is read combinationally.
module common_fifo_stream_reader_skid3
    import common_fifo_stream_reader_pkg::*;
#(
    parameter int DSIZE = 8
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             push,
    input  logic [DSIZE-1:0] din,
    input  logic             pop,
    output logic [DSIZE-1:0] dout,
    output buf_cnt_t         count
);

    logic [DSIZE-1:0] mem [STREAM_PREFETCH_DEPTH];
    logic [1:0]       wr_ptr;
    logic [1:0]       rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (count != '0);
    // A push into a full buffer is only legal when the head leaves in the same cycle.
    assign do_push = push && ((count != 2'(STREAM_PREFETCH_DEPTH)) || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STREAM_PREFETCH_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ptr_next(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/common_fifo_stream_reader.sv
// Drains a registered-read FIFO into a valid/ready stream at full rate and marks packet ends with tlast.
module common_fifo_stream_reader
    import common_fifo_stream_reader_pkg::*;
#(
    parameter int DSIZE = 8,
    parameter int LSIZE = 16
) (
    input  logic                        clock,
    input  logic                        rst_n,
    common_fifo_stream_reader_if.master bus,
    input  logic [LSIZE-1:0]            pkt_len,
    output logic [1:0]                  buf_count
);

    buf_cnt_t         occ;
    logic             inflight;
    logic             accept;
    logic [DSIZE-1:0] head;
    logic [2:0]       pending;
    logic [LSIZE-1:0] beat_cnt;
    logic [LSIZE-1:0] len_q;
    logic [LSIZE-1:0] len_cur;

    // Words already buffered plus the one arriving this cycle must leave room for one more.
    assign pending    = {1'b0, occ} + {2'b00, inflight};
    assign bus.rd_en  = rst_n && !bus.fifo_empty
                        && (pending <= 3'(STREAM_PREFETCH_DEPTH - 1));

    assign bus.tvalid = (occ != '0);
    assign bus.tdata  = head;
    assign accept     = bus.tvalid && bus.tready;
    assign buf_count  = occ;

    // The first beat of a packet sees the live length; later beats use the latched copy.
    assign len_cur    = (beat_cnt != '0) ? len_q
                      : (pkt_len == '0) ? LSIZE'(1) : pkt_len;
    assign bus.tlast  = bus.tvalid && (beat_cnt == len_cur - LSIZE'(1));

    common_fifo_stream_reader_skid3 #(
        .DSIZE (DSIZE)
    ) u_skid (
        .clock (clock),
        .rst_n (rst_n),
        .push  (inflight),
        .din   (bus.fifo_rdata),
        .pop   (accept),
        .dout  (head),
        .count (occ)
    );

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= 1'b0;
        end else begin
            inflight <= bus.rd_en;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt <= '0;
            len_q    <= LSIZE'(1);
        end else begin
            if (beat_cnt == '0) begin
                len_q <= len_cur;
            end
            if (accept) begin
                beat_cnt <= bus.tlast ? '0 : beat_cnt + LSIZE'(1);
            end
        end
    end

endmodule

// File: tb/tb_common_fifo_stream_reader.sv
// Bench for the FIFO stream reader: behavioural FIFO, queue-based scoreboard and directed phases.
module tb_common_fifo_stream_reader;
    localparam int DSIZE = 8;
    localparam int LSIZE = 16;

    logic             clock   = 1'b0;
    logic             rst_n   = 1'b0;
    logic             wr_en   = 1'b0;
    logic [LSIZE-1:0] pkt_len = 16'd4;
    logic [1:0]       buf_count;
    int               checks  = 0;
    int               passes  = 0;

    always #5 clock = ~clock;

    common_fifo_stream_reader_if #(.DSIZE(DSIZE)) bus ();

    common_fifo_stream_reader #(
        .DSIZE (DSIZE),
        .LSIZE (LSIZE)
    ) dut (
        .clock     (clock),
        .rst_n     (rst_n),
        .bus       (bus),
        .pkt_len   (pkt_len),
        .buf_count (buf_count)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Upstream FIFO, depth 4, registered read data and registered empty flag.
    logic [7:0]  fq[$];
    int unsigned wr_done = 0;
    int          fifo_sz;
    initial begin
        bus.fifo_empty = 1'b1;
        bus.fifo_rdata = '0;
        forever begin
            @(posedge clock);
            fifo_sz = fq.size();
            if (bus.rd_en && fifo_sz > 0) bus.fifo_rdata <= fq.pop_front();
            if (wr_en && fifo_sz < 4) begin
                fq.push_back(wr_done[7:0]);
                wr_done++;
            end
            bus.fifo_empty <= (fq.size() == 0);
        end
    end

    // Scoreboard: pend holds words read from the FIFO and not yet accepted, oldest first.
    logic [7:0]  pend[$];
    logic [8:0]  beat_log[$];
    int unsigned read_idx = 0;
    bit          prev_rd = 0;
    bit          prev_stall = 0;
    logic [7:0]  prev_tdata = '0;
    logic        prev_tlast = 1'b0;
    int          pkt_idx = 0;
    int          cur_len = 1;
    int          len_now;
    int          exp_occ;
    bit          exp_rd;
    initial forever begin
        @(negedge clock);
        if (!rst_n) begin
            chk("rst_rd_en", bus.rd_en, 0);
            chk("rst_tvalid", bus.tvalid, 0);
            chk("rst_tdata", bus.tdata, 0);
            chk("rst_tlast", bus.tlast, 0);
            chk("rst_buf_count", buf_count, 0);
            pend.delete();
            prev_rd = 0;
            prev_stall = 0;
            pkt_idx = 0;
            cur_len = 1;
        end else begin
            exp_occ = int'(pend.size()) - int'(prev_rd);
            chk("buf_count", buf_count, exp_occ);
            chk("tvalid", bus.tvalid, exp_occ != 0);
            chk("overflow_capture", prev_rd && (buf_count == 2'd3), 0);
            exp_rd = !bus.fifo_empty && (exp_occ + int'(prev_rd) <= 2);
            chk("rd_en", bus.rd_en, exp_rd);
            len_now = (pkt_idx == 0) ? ((pkt_len == '0) ? 1 : int'(pkt_len)) : cur_len;
            if (bus.tvalid) begin
                if (pend.size() > 0) chk("tdata", bus.tdata, pend[0]);
                else chk("tdata_no_word", 1, 0);
                chk("tlast", bus.tlast, pkt_idx == len_now - 1);
            end
            if (prev_stall) begin
                chk("stall_tdata", bus.tdata, prev_tdata);
                chk("stall_tlast", bus.tlast, prev_tlast);
            end
            if (bus.tvalid && bus.tready) begin
                beat_log.push_back({bus.tlast, bus.tdata});
                if (pend.size() > 0) void'(pend.pop_front());
                if (pkt_idx == 0) cur_len = len_now;
                if (pkt_idx + 1 == cur_len) pkt_idx = 0;
                else pkt_idx++;
            end
            if (bus.rd_en && !bus.fifo_empty) begin
                pend.push_back(read_idx[7:0]);
                read_idx++;
            end
            prev_rd    = bus.rd_en;
            prev_stall = bus.tvalid && !bus.tready;
            prev_tdata = bus.tdata;
            prev_tlast = bus.tlast;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic write_words(input int n);
        int unsigned target;
        int k;
        target = wr_done + n;
        k = 0;
        wr_en = 1'b1;
        while (wr_done < target && k < 200) begin
            step(1);
            k++;
        end
        wr_en = 1'b0;
        chk("write_timeout", wr_done >= target, 1);
    endtask

    task automatic wait_beats(input int target);
        int k;
        k = 0;
        while (beat_log.size() < target && k < 300) begin
            @(negedge clock);
            k++;
        end
        chk("beat_timeout", beat_log.size() >= target, 1);
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        wr_en = 1'b0;
        bus.tready = 1'b1;
        step(1);
        while (k < 100 && (bus.tvalid || !bus.fifo_empty || bus.rd_en || buf_count != 0)) begin
            step(1);
            k++;
        end
        chk(name, k < 100, 1);
        step(2);
    endtask

    initial begin
        int k;
        int gaps;
        bit seen;
        int base;
        int unsigned w_start;
        bus.tready = 1'b1;
        pkt_len = 16'd4;
        rst_n = 1'b0;

        // Phase 1: preload 0..3 while held in reset, then release.
        wr_en = 1'b1;
        step(4);
        wr_en = 1'b0;
        step(2);
        rst_n = 1'b1;
        @(negedge clock);
        chk("p1_rd_en_at_release", bus.rd_en, 1);
        k = 0;
        while (!bus.tvalid && k < 10) begin
            @(negedge clock);
            k++;
        end
        chk("p1_valid_latency", k, 2);
        for (int i = 0; i < 4; i++) begin
            chk("p1_beat_valid", bus.tvalid, 1);
            chk("p1_beat_data", bus.tdata, i);
            chk("p1_beat_tlast", bus.tlast, i == 3);
            @(negedge clock);
        end

        // Phase 2: continuous writes with tready high.
        step(1);
        wr_en = 1'b1;
        gaps = 0;
        seen = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (bus.tvalid) seen = 1;
            else if (seen) gaps++;
        end
        chk("p2_gaps", gaps, 0);
        chk("p2_steady_occ", buf_count, 1);
        chk("p2_steady_rd_en", bus.rd_en, 1);

        // Phase 3: ten cycles of back-pressure, then release.
        step(1);
        bus.tready = 1'b0;
        step(10);
        @(negedge clock);
        chk("p3_saturated", buf_count, 3);
        chk("p3_rd_en_low", bus.rd_en, 0);
        chk("p3_valid_held", bus.tvalid, 1);
        step(1);
        bus.tready = 1'b1;
        @(negedge clock);
        chk("p3_release_beat", bus.tvalid, 1);
        @(negedge clock);
        chk("p3_rd_resume", bus.rd_en, 1);
        step(30);
        drain("p3_drain");

        // Phase 4: packet framing.
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        pkt_len = 16'd4;
        base = beat_log.size();
        write_words(12);
        wait_beats(base + 12);
        for (int i = 0; i < 12; i++)
            chk("p4_tlast_len4", beat_log[base + i][8], (i % 4) == 3);
        drain("p4a_drain");

        pkt_len = 16'd0;
        base = beat_log.size();
        write_words(4);
        wait_beats(base + 4);
        for (int i = 0; i < 4; i++)
            chk("p4_tlast_len0", beat_log[base + i][8], 1);
        drain("p4b_drain");

        pkt_len = 16'd4;
        base = beat_log.size();
        fork
            write_words(12);
            begin
                wait_beats(base + 5);
                @(posedge clock);
                #1;
                pkt_len = 16'd2;
            end
        join
        wait_beats(base + 12);
        for (int i = 0; i < 12; i++)
            chk("p4_tlast_change", beat_log[base + i][8], (i == 3) || (i == 7) || (i == 9) || (i == 11));
        drain("p4c_drain");

        // Phase 5: random write and ready activity.
        pkt_len = 16'd3;
        base = beat_log.size();
        w_start = wr_done;
        for (int i = 0; i < 5000; i++) begin
            wr_en = 1'($urandom_range(0, 1));
            bus.tready = 1'($urandom_range(0, 1));
            step(1);
        end
        drain("p5_drain");
        chk("p5_all_words_out", beat_log.size() - base, wr_done - w_start);

        // Phase 6: reset with a full prefetch buffer.
        pkt_len = 16'd2;
        w_start = wr_done;
        bus.tready = 1'b0;
        wr_en = 1'b1;
        k = 0;
        while (buf_count != 2'd3 && k < 20) begin
            step(1);
            k++;
        end
        chk("p6_buffer_full", buf_count, 3);
        step(4);
        wr_en = 1'b0;
        step(1);
        rst_n = 1'b0;
        #1;
        chk("p6_async_tvalid", bus.tvalid, 0);
        chk("p6_async_tdata", bus.tdata, 0);
        chk("p6_async_tlast", bus.tlast, 0);
        chk("p6_async_buf_count", buf_count, 0);
        chk("p6_async_rd_en", bus.rd_en, 0);
        step(2);
        rst_n = 1'b1;
        bus.tready = 1'b1;
        k = 0;
        while (!bus.tvalid && k < 10) begin
            @(negedge clock);
            k++;
        end
        chk("p6_first_data", bus.tdata, (w_start + 3) & 32'hff);
        chk("p6_first_tlast", bus.tlast, 0);
        @(negedge clock);
        chk("p6_second_data", bus.tdata, (w_start + 4) & 32'hff);
        chk("p6_second_tlast", bus.tlast, 1);
        drain("p6_drain");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passes, checks);
        $fatal(1);
    end

endmodule

// File: doc/common_fifo_stream_reader.md
# common_fifo_stream_reader

Read-side adapter that drains a `common_fifo` (registered read, one-cycle read latency) and presents its words as a valid/ready stream with full one-beat-per-cycle throughput. It also inserts a `tlast` marker every `pkt_len` accepted beats. It sits directly downstream of `common_fifo`: it drives the FIFO's `rd_en` and consumes `rdata`/`empty`. It absorbs read latency and downstream back-pressure in a 3-entry prefetch buffer.

## Interface
Parameters:
- `DSIZE`, 8, data width; must match the upstream `common_fifo` `DSIZE`.
- `LSIZE`, 16, width of the packet-length port and the beat counter.

Ports:
- `clock`  in  1  single clock for all logic.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `fifo_rdata`  in  DSIZE  FIFO read data; valid the cycle after an accepted `rd_en`.
- `fifo_empty`  in  1  FIFO empty flag, registered in the FIFO.
- `rd_en`  out  1  FIFO read strobe.
- `pkt_len`  in  LSIZE  beats per packet; latched at each packet start; 0 is treated as 1.
- `tdata`  out  DSIZE  stream data.
- `tvalid`  out  1  stream valid.
- `tready`  in  1  stream ready from the downstream consumer.
- `tlast`  out  1  last beat of the packet; qualified by `tvalid`.
- `buf_count`  out  2  number of words held in the prefetch buffer (0..3).

## Operation
- Internal state:
  - `occ` = buffered words (0..3).
  - `inflight` = 1 if `rd_en` was asserted last cycle.
  - Buffer: 3-entry FIFO-ordered storage; the head drives `tdata`.
- Read issue: `rd_en = !fifo_empty && (occ + inflight <= 2)`.
  - `rd_en` depends only on registered state plus `fifo_empty`. There is no combinational path from `tready` to `rd_en`.
  - The 3-entry buffer guarantees no overflow even with `tready` low.
- Capture: when `inflight` is 1, `fifo_rdata` is written at the tail at the end of that cycle.
- Pop: a beat is accepted when `tvalid && tready`; the head advances.
- Push and pop in the same cycle: `occ` is unchanged and ordering is preserved.
- `tvalid = (occ != 0)`.
- `tdata` and `tlast` hold stable while `tvalid && !tready`.
- Packet counter `beat_cnt` (LSIZE bits):
  - Increments on each accepted beat.
  - Clears to 0 on the accepted beat where `tlast` = 1.
  - `len_q` is latched from `pkt_len` when `beat_cnt == 0`; the value is forced to 1 if `pkt_len` is 0.
  - `tlast = tvalid && (beat_cnt == len_q - 1)`.
  - A change of `pkt_len` mid-packet has no effect until the next packet.
- Overflow protection:
  - Capture when `occ == 3` cannot occur by construction.
  - The bench asserts this.
  - RTL does not need to drop data.

## Timing
- Reset values (asynchronous, while `rst_n` = 0):
  - `rd_en` = 0. It is forced low during reset regardless of `fifo_empty`.
  - `tvalid` = 0, `tdata` = 0, `tlast` = 0, `buf_count` = 0.
  - Internally: `occ` = 0, `inflight` = 0, `beat_cnt` = 0, `len_q` = 1.
- Reset mid-operation:
  - Buffered and in-flight words are discarded.
  - The packet counter restarts.
  - Any FIFO read issued in the cycle before reset is lost; this is accepted.
- Latency: `fifo_empty` falls in cycle N → `rd_en` high in N → `fifo_rdata` valid in N+1 → `tvalid` high in N+2.
- Throughput: with `tready` held high and the FIFO non-empty, one beat per cycle is sustained indefinitely.
  - Steady state is `occ` = 1 and `inflight` = 1.
- Back-pressure: with `tready` low, at most 3 further reads complete; then `rd_en` stays low.
- Release after stall: `tready` rising in cycle M gives a beat in M; `rd_en` resumes in M+1 at the latest.
- `fifo_empty` rising: `rd_en` drops in the same cycle. Already-buffered words continue to drain.

## Structure
- Shared constant in `BaseFuncPkg`: `STREAM_PREFETCH_DEPTH = 3`.
- One sub-module, `common_fifo_skid3`:
  - A 3-entry ordered buffer with push, pop, head data and count.
  - Used with pointer-based storage, no shifting.
- Issue logic and the packet counter live in the top module.

## Test plan
- Reset then fill: `common_fifo` (DEPTH 4) is pre-loaded with 0x00..0x03 and `tready` = 1 → `tvalid` first goes high 2 cycles after `fifo_empty` falls. Beats 0x00..0x03 appear on consecutive cycles.
- Full-throughput stream: `wr_en` and `tready` held at 1 for 200 cycles with an incrementing `wdata` → `tdata` strictly increments by 1, with no gaps after the initial latency.
- Back-pressure: `tready` = 0 for 10 cycles mid-stream → `buf_count` saturates at 3, `rd_en` stays low and `tdata` is stable. On release the sequence continues with no loss or duplication.
- Packets: `pkt_len` = 4 → `tlast` on beats 3, 7, 11. With `pkt_len` = 0, `tlast` is set on every beat. Changing `pkt_len` to 2 at beat 5 takes effect from beat 8.
- Random: `random_signal(pclk,100,50,...)` drives `wr_en` and `tready` for 5000 cycles → the scoreboard matches every word in order and never sees an overflow capture.
- Mid-run reset: `rst_n` is pulsed low with `occ` = 3 → all outputs are 0 immediately. After release, the first beat has `beat_cnt` = 0 and is the FIFO's next word.
